pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register. It is the generic successor of the fixed-field inter-stage registers and is instantiated at every boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque payload plus a valid bit, and decodes the stall vector from the ctrl module to decide, per cycle, whether to advance, hold or insert a bubble. It also supports a flush input and provides saturating stall and bubble performance counters.

Parameters:
DATA_W, 32, payload width in bits (1..256).
NOP_VALUE, all-zero, payload value driven for bubbles and reset; DATA_W bits wide.
CTRL_W, 6, width of the ctrl stall vector.
STAGE, 2, index of the producing stage's stall bit; 0..CTRL_W-1.
CNT_W, 16, width of each perf counter (2..32).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  producing stage has a valid instruction.
in_data  in  DATA_W  producing stage payload.
ctrl_stall  in  CTRL_W  stall vector from ctrl; bit i set means stage i stalls.
flush  in  1  squash the register contents (exception/branch redirect).
cnt_clr  in  1  clear both perf counters.
out_valid  out  1  registered valid to the consuming stage.
out_data  out  DATA_W  registered payload to the consuming stage.
stall_cnt  out  CNT_W  number of cycles with ctrl_stall[STAGE]=1; saturating.
bubble_cnt  out  CNT_W  number of bubbles inserted; saturating.

Behaviour:
- Derived signals:
  - s_here = ctrl_stall[STAGE].
  - s_next = ctrl_stall[STAGE+1]. When STAGE==CTRL_W-1, s_next is constant 0.
- Register update per rising edge, strict priority:
  1. rst: out_valid<=0, out_data<=NOP_VALUE.
  2. flush: out_valid<=0, out_data<=NOP_VALUE, regardless of stall bits.
  3. bubble (s_here=1, s_next=0): out_valid<=0, out_data<=NOP_VALUE.
  4. advance (s_here=0): out_valid<=in_valid; out_data<=in_valid ? in_data : NOP_VALUE.
  5. hold (s_here=1, s_next=1): out_valid and out_data keep their values.
- Latency is one cycle on advance. There is no combinational path from any input to any output.
- Counters (both reset to 0 on rst):
  - stall_cnt increments when s_here=1 and flush=0.
  - bubble_cnt increments on each priority-3 cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr loads 0 and takes precedence over any increment in the same cycle.
  - rst overrides cnt_clr.
  - Flush cycles count neither a stall nor a bubble.
- Reset mid-stall: after reset release the block resumes normal behaviour on the next edge. No stale hold state remains.
- A flush during hold discards the held payload. The following cycle obeys the stall bits afresh.
- The ctrl vector shape is legal only when monotonic (stall[i]=1 implies stall[i-1]=1). Non-monotonic vectors still follow the priority table above, and the checker flags them.
- Out-of-range STAGE triggers an elaboration-time error via a generate-if with a $error call.

Decomposition:
- Shared package cpu_pkg holds:
  - ZeroWord, RstEnable, NOPRegAddr.
  - Stall vector index constants: STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB.
  - CTRL_W default.
  - NOP payload constants per boundary, packed from EXE_NOP_OP / EXE_RES_NOP / WriteDisable fields.
- One sub-module, sat_counter (parameters CNT_W; inputs inc, clr), instantiated twice for stall_cnt and bubble_cnt.

Test Plan:
- Reset with rst=1 for 2 cycles, in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=NOP_VALUE, both counters 0.
- STAGE=2, ctrl_stall=000000, in_data=0x12345678 valid -> next edge out_valid=1, out_data=0x12345678; 5 back-to-back values appear in order with 1-cycle latency.
- ctrl_stall=000111 (bubble) for 1 cycle -> out_valid=0, out_data=NOP_VALUE, bubble_cnt=1, stall_cnt=1.
- ctrl_stall=001111 (hold) for 3 cycles with in_data changing -> out_data keeps the previous value; stall_cnt+3, bubble_cnt unchanged.
- flush=1 during hold with ctrl_stall=001111 -> out_valid=0, out_data=NOP_VALUE, no counter increments; the next cycle with ctrl_stall=0 loads the new in_data.
- CNT_W=2, 5 consecutive bubble cycles -> bubble_cnt saturates at 3; cnt_clr=1 together with a bubble -> bubble_cnt=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants for the pipeline. Holds the classic zero and disable
// encodings, the stall-vector bit index of every stage, the default ctrl
// vector width, and the NOP payload for each inter-stage boundary. The NOP
// payloads are built from the same fields the decoder uses, so a bubble
// looks exactly like a decoded "do nothing" instruction downstream.
// It also holds the enum that names the per-cycle action of a boundary
// register.
// No ports (package).
package cpu_pkg;

    // Basic encodings
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        RstEnable    = 1'b1;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;

    // Bit index of each stage in the ctrl stall vector
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int CTRL_W_DEF = 6;

    // IF/ID payload: {pc, instruction}
    localparam int IFID_W = 64;
    localparam logic [IFID_W-1:0] IFID_NOP = {ZeroWord, ZeroWord};

    // ID/EX payload: {aluop, alusel, reg1, reg2, wd, wreg}
    localparam int IDEX_W = 81;
    localparam logic [IDEX_W-1:0] IDEX_NOP = {EXE_NOP_OP, EXE_RES_NOP,
                                              ZeroWord, ZeroWord,
                                              NOPRegAddr, WriteDisable};

    // EX/MEM and MEM/WB payload: {wd, wreg, wdata}
    localparam int EXMEM_W = 38;
    localparam logic [EXMEM_W-1:0] EXMEM_NOP = {NOPRegAddr, WriteDisable, ZeroWord};
    localparam int MEMWB_W = 38;
    localparam logic [MEMWB_W-1:0] MEMWB_NOP = {NOPRegAddr, WriteDisable, ZeroWord};

    // What a boundary register does on a given cycle (reset aside)
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_action_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter
// Saturating up-counter used for the boundary performance counters.
// Sticks at all-ones instead of wrapping so a long run never reads as short.
// Ports:
//   clk  in        clock
//   rst  in        synchronous active-high reset, clears the count
//   inc  in        count this cycle
//   clr  in        load zero; beats inc, loses to rst
//   cnt  out CNT_W current count
module sat_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic pipeline boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries an opaque payload plus valid, and uses the ctrl stall vector to
// advance, hold or insert a bubble each cycle. Flush squashes the contents.
// Two saturating counters record stall cycles and inserted bubbles.
// All outputs come straight from flops.
// Ports:
//   clk         in             clock
//   rst         in             synchronous active-high reset
//   in_valid    in             producing stage has a valid instruction
//   in_data     in  DATA_W     producing stage payload
//   ctrl_stall  in  CTRL_W     stall vector, bit i = stage i stalls
//   flush       in             squash contents
//   cnt_clr     in             clear both perf counters
//   out_valid   out            registered valid
//   out_data    out DATA_W     registered payload
//   stall_cnt   out CNT_W      cycles with this stage stalled (not flushed)
//   bubble_cnt  out CNT_W      bubbles inserted
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CTRL_W    = CTRL_W_DEF,
    parameter int                STAGE     = STG_ID,
    parameter int                CNT_W     = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] ctrl_stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_s_here;
    logic              w_s_next;
    logic [CTRL_W-1:0] w_ctrl_gap;
    stage_action_t     w_action;
    logic              w_stall_inc;
    logic              w_bubble_inc;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // The last stage has no consumer that can stall, so it never holds.
    generate
        if ((STAGE < 0) || (STAGE >= CTRL_W)) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE %0d outside 0..%0d", STAGE, CTRL_W - 1);
            assign w_s_here = 1'b0;
            assign w_s_next = 1'b0;
        end else if (STAGE == CTRL_W - 1) begin : g_last_stage
            assign w_s_here = ctrl_stall[STAGE];
            assign w_s_next = 1'b0;
        end else begin : g_mid_stage
            assign w_s_here = ctrl_stall[STAGE];
            assign w_s_next = ctrl_stall[STAGE + 1];
        end
    endgenerate

    // Bit i of the gap vector is set when stage i+1 stalls but stage i does
    // not, which ctrl should never produce.
    assign w_ctrl_gap = (ctrl_stall >> 1) & ~ctrl_stall;

    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            assert (w_ctrl_gap == '0);
        end
    end

    // Flush beats every stall combination; otherwise the pair of stall bits
    // picks the action.
    always_comb begin
        w_action = ACT_HOLD;
        if (flush) begin
            w_action = ACT_FLUSH;
        end else if (!w_s_here) begin
            w_action = ACT_ADVANCE;
        end else if (!w_s_next) begin
            w_action = ACT_BUBBLE;
        end
    end

    // An invalid instruction advances as a clean NOP payload rather than
    // leaking whatever the producer left on its data lines.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else begin
            case (w_action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_data  <= NOP_VALUE;
                end
                ACT_ADVANCE: begin
                    r_valid <= in_valid;
                    r_data  <= in_valid ? in_data : NOP_VALUE;
                end
                default: begin
                    r_valid <= r_valid;
                    r_data  <= r_data;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

    assign w_stall_inc  = w_s_here && (w_action != ACT_FLUSH);
    assign w_bubble_inc = (w_action == ACT_BUBBLE);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_bubble_inc),
        .clr (cnt_clr),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. Two instances share the same inputs:
// one with 16-bit counters and one with 2-bit counters to reach saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inData;
    logic [5:0]  ctrlStall;
    logic        flush;
    logic        cntClr;

    logic        outValid;
    logic [31:0] outData;
    logic [15:0] stallCnt;
    logic [15:0] bubbleCnt;

    logic        satValid;
    logic [31:0] satData;
    logic [1:0]  satStall;
    logic [1:0]  satBubble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W    (32),
        .NOP_VALUE (32'h0000_0000),
        .CTRL_W    (6),
        .STAGE     (2),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_data    (inData),
        .ctrl_stall (ctrlStall),
        .flush      (flush),
        .cnt_clr    (cntClr),
        .out_valid  (outValid),
        .out_data   (outData),
        .stall_cnt  (stallCnt),
        .bubble_cnt (bubbleCnt)
    );

    pipe_stage_reg #(
        .DATA_W    (32),
        .NOP_VALUE (32'h0000_0000),
        .CTRL_W    (6),
        .STAGE     (2),
        .CNT_W     (2)
    ) dutSat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_data    (inData),
        .ctrl_stall (ctrlStall),
        .flush      (flush),
        .cnt_clr    (cntClr),
        .out_valid  (satValid),
        .out_data   (satData),
        .stall_cnt  (satStall),
        .bubble_cnt (satBubble)
    );

    // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                                 input logic [5:0] c, input logic f, input logic cc);
        rst       = r;
        inValid   = v;
        inData    = d;
        ctrlStall = c;
        flush     = f;
        cntClr    = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkMain(input string tag, input logic v, input logic [31:0] d,
                             input logic [15:0] sc, input logic [15:0] bc);
        checkOutput({tag, ".valid"},  {31'b0, outValid}, {31'b0, v});
        checkOutput({tag, ".data"},   outData, d);
        checkOutput({tag, ".stall"},  {16'b0, stallCnt}, {16'b0, sc});
        checkOutput({tag, ".bubble"}, {16'b0, bubbleCnt}, {16'b0, bc});
    endtask

    task automatic checkSat(input string tag, input logic [1:0] sc, input logic [1:0] bc);
        checkOutput({tag, ".satStall"},  {30'b0, satStall}, {30'b0, sc});
        checkOutput({tag, ".satBubble"}, {30'b0, satBubble}, {30'b0, bc});
    endtask

    initial begin
        $display("[TB] start");

        // Reset for two cycles with a valid input present
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b0, 1'b0);
        checkMain("reset", 1'b0, 32'h0, 16'd0, 16'd0);
        checkSat("reset", 2'd0, 2'd0);
        checkOutput("reset.satValid", {31'b0, satValid}, 32'd0);
        checkOutput("reset.satData", satData, 32'h0);

        // First advance, one-cycle latency
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 6'b000000, 1'b0, 1'b0);
        checkMain("adv0", 1'b1, 32'h1234_5678, 16'd0, 16'd0);

        // Back-to-back stream
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hA000_0000 + i, 6'b000000, 1'b0, 1'b0);
            checkOutput("stream.data", outData, 32'hA000_0000 + i);
            checkOutput("stream.valid", {31'b0, outValid}, 32'd1);
        end

        // Invalid instruction advances as NOP payload
        applyStimulus(1'b0, 1'b0, 32'hCAFE_F00D, 6'b000000, 1'b0, 1'b0);
        checkMain("advInvalid", 1'b0, 32'h0, 16'd0, 16'd0);

        // Bubble: this stage stalls, the next does not
        applyStimulus(1'b0, 1'b1, 32'h5555_5555, 6'b000111, 1'b0, 1'b0);
        checkMain("bubble", 1'b0, 32'h0, 16'd1, 16'd1);
        checkSat("bubble", 2'd1, 2'd1);

        // Load a value to hold
        applyStimulus(1'b0, 1'b1, 32'hABCD_0001, 6'b000000, 1'b0, 1'b0);
        checkMain("preHold", 1'b1, 32'hABCD_0001, 16'd1, 16'd1);

        // Hold three cycles with changing input
        applyStimulus(1'b0, 1'b1, 32'h1111_0000, 6'b001111, 1'b0, 1'b0);
        checkMain("hold1", 1'b1, 32'hABCD_0001, 16'd2, 16'd1);
        applyStimulus(1'b0, 1'b1, 32'h2222_0000, 6'b001111, 1'b0, 1'b0);
        checkMain("hold2", 1'b1, 32'hABCD_0001, 16'd3, 16'd1);
        applyStimulus(1'b0, 1'b0, 32'h3333_0000, 6'b001111, 1'b0, 1'b0);
        checkMain("hold3", 1'b1, 32'hABCD_0001, 16'd4, 16'd1);
        checkSat("hold3", 2'd3, 2'd1);

        // Flush during hold: squash, no counting
        applyStimulus(1'b0, 1'b1, 32'h9999_9999, 6'b001111, 1'b1, 1'b0);
        checkMain("flush", 1'b0, 32'h0, 16'd4, 16'd1);

        // Next cycle obeys stall bits afresh
        applyStimulus(1'b0, 1'b1, 32'h7777_7777, 6'b000000, 1'b0, 1'b0);
        checkMain("postFlush", 1'b1, 32'h7777_7777, 16'd4, 16'd1);

        // Five bubbles: the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h4444_0000 + i, 6'b000111, 1'b0, 1'b0);
            checkOutput("sat.bubble", {16'b0, bubbleCnt}, 32'd2 + i);
            checkOutput("sat.stall", {16'b0, stallCnt}, 32'd5 + i);
            checkOutput("sat.satBubble", {30'b0, satBubble}, (i == 0) ? 32'd2 : 32'd3);
        end
        checkSat("satEnd", 2'd3, 2'd3);

        // Clear wins over a simultaneous bubble
        applyStimulus(1'b0, 1'b1, 32'h4444_1000, 6'b000111, 1'b0, 1'b1);
        checkMain("clr", 1'b0, 32'h0, 16'd0, 16'd0);
        checkSat("clr", 2'd0, 2'd0);

        applyStimulus(1'b0, 1'b1, 32'h4444_2000, 6'b000111, 1'b0, 1'b0);
        checkMain("postClr", 1'b0, 32'h0, 16'd1, 16'd1);

        // Reset in the middle of a hold, then resume
        applyStimulus(1'b0, 1'b1, 32'h6666_0000, 6'b001111, 1'b0, 1'b0);
        checkMain("preRst", 1'b0, 32'h0, 16'd2, 16'd1);
        applyStimulus(1'b1, 1'b1, 32'h6666_1000, 6'b001111, 1'b0, 1'b0);
        checkMain("midRst", 1'b0, 32'h0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 32'h0BAD_F00D, 6'b000000, 1'b0, 1'b0);
        checkMain("postRst", 1'b1, 32'h0BAD_F00D, 16'd0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
